// File: rtl/fp_mul_pipe_pkg.sv
// Shared constants and types for the pipelined floating-point multiplier.
// Defaults describe IEEE-754 binary64.
package fpPkg;

    localparam int FP_EXPW  = 11;
    localparam int FP_FRACW = 52;

    typedef struct packed {
        logic inf;
        logic overflow;
        logic underflow;
        logic invalid;
        logic sign_exe;
    } fp_mul_flags_t;

    // Quiet-NaN payload: quiet bit set plus a marker in the low bits
    localparam logic [FP_FRACW-1:0] FP_QNAN_PAYLOAD = {1'b1, {(FP_FRACW-4){1'b0}}, 3'd4};

endpackage

// File: rtl/fp_mul_pipe_mant.sv
// Unsigned W x W significand multiplier, STAGES registers deep.
// Every register advances on the shared pipeline enable.
module mant_mul_pipe
    import fpPkg::*;
#(
    parameter int W      = FP_FRACW + 1,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [W-1:0]     i_a,
    input  logic [W-1:0]     i_b,
    output logic [2*W-1:0]   o_p
);

    logic [2*W-1:0] r_p [STAGES];

    // Product register followed by retiming stages for the synthesis tool
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) r_p[i] <= '0;
        end else if (i_en) begin
            r_p[0] <= (2*W)'(i_a) * (2*W)'(i_b);
            for (int i = 1; i < STAGES; i++) r_p[i] <= r_p[i-1];
        end
    end

    assign o_p = r_p[STAGES-1];

endmodule

// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-754 multiplier producing the unrounded double-width significand.
// Decode -> MSTAGES multiplier stages -> special-case select, with valid/ready stall.
module fp_mul_pipe
    import fpPkg::*;
#(
    parameter int EXPW    = FP_EXPW,
    parameter int FRACW   = FP_FRACW,
    parameter int MSTAGES = 4,
    parameter int TAGW    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXPW+FRACW:0]       a,
    input  logic [EXPW+FRACW:0]       b,
    input  logic [TAGW-1:0]           in_tag,
    input  logic                      daz,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      o_sign,
    output logic [EXPW-1:0]           o_exp,
    output logic [2*(FRACW+1)-1:0]    o_sig,
    output logic [TAGW-1:0]           out_tag,
    output logic                      inf,
    output logic                      overflow,
    output logic                      underflow,
    output logic                      invalid,
    output logic                      sign_exe
);

    localparam int SIGW = FRACW + 1;
    localparam int PW   = 2 * SIGW;
    localparam int EXW  = EXPW + 2;
    localparam logic [EXW-1:0]   BIAS         = EXW'((1 << (EXPW - 1)) - 1);
    localparam logic [FRACW-1:0] QNAN_MSB     = {1'b1, {(FRACW-1){1'b0}}};
    localparam logic [FRACW-1:0] QNAN_PAYLOAD = QNAN_MSB | FRACW'(3'd4);

    typedef struct packed {
        logic             valid;
        logic             sign;
        logic             sign_exe;
        logic [EXW-1:0]   ex1;
        logic             a_nan;
        logic             b_nan;
        logic             inf_zero;
        logic             any_inf;
        logic             daz;
        logic [TAGW-1:0]  tag;
        logic [FRACW-1:0] fa;
        logic [FRACW-1:0] fb;
    } side_t;

    logic            w_adv;
    logic [EXPW-1:0] w_xa, w_xb;
    logic [FRACW-1:0] w_fa, w_fb;
    logic            w_a_zero, w_b_zero, w_a_dn, w_b_dn;
    logic            w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_kill;
    logic [EXW-1:0]  w_ex_sum;
    logic [SIGW-1:0] w_ma, w_mb;
    side_t           w_s0;

    side_t           r_s0;
    logic [SIGW-1:0] r_ma, r_mb;
    side_t           r_sb [MSTAGES];
    logic [PW-1:0]   w_prod;

    side_t           w_sl;
    logic            w_uf, w_of, w_inv;
    logic [EXPW-1:0] w_exp_n;
    logic [PW-1:0]   w_sig_n;
    fp_mul_flags_t   w_flags;

    logic            r_out_valid, r_sign;
    logic [EXPW-1:0] r_exp;
    logic [PW-1:0]   r_sig;
    logic [TAGW-1:0] r_tag;
    fp_mul_flags_t   r_flags;

    // The whole pipeline moves as one; a held output freezes every stage behind it
    assign w_adv    = ce & ~rst & (~r_out_valid | out_ready);
    assign in_ready = w_adv;

    // Operand classification and biased exponent sum
    always_comb begin
        w_xa     = a[FRACW +: EXPW];
        w_xb     = b[FRACW +: EXPW];
        w_fa     = a[FRACW-1:0];
        w_fb     = b[FRACW-1:0];
        w_a_zero = (w_xa == '0) && (w_fa == '0);
        w_b_zero = (w_xb == '0) && (w_fb == '0);
        w_a_dn   = (w_xa == '0) && (w_fa != '0);
        w_b_dn   = (w_xb == '0) && (w_fb != '0);
        w_a_inf  = (&w_xa) && (w_fa == '0);
        w_b_inf  = (&w_xb) && (w_fb == '0);
        w_a_nan  = (&w_xa) && (w_fa != '0);
        w_b_nan  = (&w_xb) && (w_fb != '0);
        w_kill   = w_a_zero | w_b_zero | (daz & (w_a_dn | w_b_dn));
        // Denormals carry an effective exponent of 1
        w_ex_sum = {2'b00, w_xa | EXPW'(w_a_dn)} + {2'b00, w_xb | EXPW'(w_b_dn)} - BIAS;
        w_ma     = (daz & w_a_dn) ? '0 : {(w_xa != '0), w_fa};
        w_mb     = (daz & w_b_dn) ? '0 : {(w_xb != '0), w_fb};

        w_s0          = '0;
        w_s0.valid    = in_valid;
        w_s0.sign     = a[EXPW+FRACW] ^ b[EXPW+FRACW];
        w_s0.sign_exe = a[EXPW+FRACW] & b[EXPW+FRACW];
        w_s0.ex1      = w_kill ? '0 : w_ex_sum;
        w_s0.a_nan    = w_a_nan;
        w_s0.b_nan    = w_b_nan;
        w_s0.inf_zero = (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
        w_s0.any_inf  = w_a_inf | w_b_inf;
        w_s0.daz      = daz;
        w_s0.tag      = in_tag;
        w_s0.fa       = w_fa;
        w_s0.fb       = w_fb;
    end

    // Stage 0: decoded operands and multiplier inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0 <= '0;
            r_ma <= '0;
            r_mb <= '0;
        end else if (w_adv) begin
            r_s0 <= w_s0;
            r_ma <= w_ma;
            r_mb <= w_mb;
        end
    end

    mant_mul_pipe #(
        .W      (SIGW),
        .STAGES (MSTAGES)
    ) u_mant (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_adv),
        .i_a  (r_ma),
        .i_b  (r_mb),
        .o_p  (w_prod)
    );

    // Side-band shift register kept aligned with the multiplier stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MSTAGES; i++) r_sb[i] <= '0;
        end else if (w_adv) begin
            r_sb[0] <= r_s0;
            for (int i = 1; i < MSTAGES; i++) r_sb[i] <= r_sb[i-1];
        end
    end

    // Range flags and prioritised special-case selection
    always_comb begin
        w_sl    = r_sb[MSTAGES-1];
        w_uf    = w_sl.ex1[EXW-1];
        w_of    = (&w_sl.ex1[EXPW-1:0] | w_sl.ex1[EXPW]) & ~w_sl.ex1[EXW-1];
        w_inv   = 1'b0;
        w_exp_n = w_sl.ex1[EXPW-1:0];
        w_sig_n = w_prod;
        if (w_sl.a_nan) begin
            w_exp_n = '1;
            w_sig_n = {1'b1, w_sl.fa | QNAN_MSB, {SIGW{1'b0}}};
        end else if (w_sl.b_nan) begin
            w_exp_n = '1;
            w_sig_n = {1'b1, w_sl.fb | QNAN_MSB, {SIGW{1'b0}}};
        end else if (w_sl.inf_zero) begin
            w_exp_n = '1;
            w_sig_n = {1'b1, QNAN_PAYLOAD, {SIGW{1'b0}}};
            w_inv   = 1'b1;
        end else if (w_sl.any_inf | w_of) begin
            w_exp_n = '1;
            w_sig_n = '0;
        end else if (w_uf) begin
            w_sig_n = w_sl.daz ? '0 : w_prod;
        end else begin
            w_sig_n = w_prod;
        end
        w_flags.inf       = w_of;
        w_flags.overflow  = w_of;
        w_flags.underflow = w_uf;
        w_flags.invalid   = w_inv;
        w_flags.sign_exe  = w_sl.sign_exe;
    end

    // Final stage: registered result and status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_sig       <= '0;
            r_tag       <= '0;
            r_flags     <= '0;
        end else if (w_adv) begin
            r_out_valid <= w_sl.valid;
            r_sign      <= w_sl.sign;
            r_exp       <= w_exp_n;
            r_sig       <= w_sig_n;
            r_tag       <= w_sl.tag;
            r_flags     <= w_flags;
        end
    end

    assign out_valid = r_out_valid;
    assign o_sign    = r_sign;
    assign o_exp     = r_exp;
    assign o_sig     = r_sig;
    assign out_tag   = r_tag;
    assign inf       = r_flags.inf;
    assign overflow  = r_flags.overflow;
    assign underflow = r_flags.underflow;
    assign invalid   = r_flags.invalid;
    assign sign_exe  = r_flags.sign_exe;

endmodule
